// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receive path:
//   rx_state_e - receiver frame states
//   DATA_BITS  - data bits per frame (8N1)
//   cnt_width  - width of a down-counter that must hold CLKS_PER_BIT-1
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int DATA_BITS = 8;

    // Never return zero, so a degenerate divider still yields a legal vector.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/serialc_rx_sync2.sv
// sync2
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL, so an idle-high line does not look like an
// edge when reset is released.
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset
//   d_i   - asynchronous input
//   q_o   - synchronised output (two clocks of latency)
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serialc_rx.sv
// serialc_rx
// 8N1 UART receiver, LSB first. Samples each bit at its centre and emits a
// one-cycle EN strobe with the received byte on DATA. Frames with a bad stop
// bit are discarded, and the receiver then waits for the line to return high.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   RXD  - serial line, asynchronous to CLK, idle high
//   DATA - last correctly received byte, held between frames
//   EN   - one-cycle strobe; DATA is valid in the same cycle
module serialc_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       EN
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    // Half a bit period from the detected start edge lands on the start-bit
    // centre; every later full period then lands on a bit centre.
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           data_q,  data_d;
    logic                 en_q,    en_d;
    logic                 rxs;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_rxd (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (RXD),
        .q_o   (rxs)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        en_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    // Line went high again before mid start bit: treat it as noise.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d[idx_q] = rxs;
                    cnt_d          = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    // Returning to IDLE at mid stop bit leaves half a bit of
                    // margin to catch a start bit that follows with no gap.
                    data_d  = shreg_q;
                    en_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                // A held-low line (break) must not be decoded as a stream of
                // zero bytes, so wait for the line to go high first.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DATA = data_q;
    assign EN   = en_q;

endmodule

// File: tb/tb_serialc_rx.sv
`timescale 1ns/1ps
module tb_serialc_rx;

    localparam int CPB_A = 8;
    localparam int CPB_B = 868;
    localparam int LAT_A = 3 + CPB_A / 2 + 9 * CPB_A;
    localparam int LAT_B = 3 + CPB_B / 2 + 9 * CPB_B;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       en_a, en_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one entry per frame sent with a good stop bit, holding
    // the byte and the cycle at which its start edge was driven.
    logic [7:0] exp_a[$], exp_b[$];
    int         t0_a[$],  t0_b[$];
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    logic       en_prev_a = 1'b0, en_prev_b = 1'b0;
    int         en_cnt_a = 0, en_cnt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serialc_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .CLK (clk), .RST (rst_a), .RXD (rxd_a), .DATA (data_a), .EN (en_a)
    );

    serialc_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .CLK (clk), .RST (rst_b), .RXD (rxd_b), .DATA (data_b), .EN (en_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitors: every EN pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst_a) begin
            last_a = 8'h00;
            en_prev_a = 1'b0;
        end else begin
            if (en_a) begin
                int lat;
                check("a_en_double", {31'b0, en_prev_a}, 32'd0);
                check("a_en_expected", {31'b0, (exp_a.size() > 0)}, 32'd1);
                if (exp_a.size() > 0) begin
                    check("a_data", {24'b0, data_a}, {24'b0, exp_a.pop_front()});
                    lat = cyc - t0_a.pop_front();
                    check("a_latency", lat, (lat >= LAT_A - 1 && lat <= LAT_A + 1) ? lat : LAT_A);
                end
                last_a = data_a;
                en_cnt_a++;
            end else if (data_a !== last_a) begin
                check("a_data_stable", {24'b0, data_a}, {24'b0, last_a});
                last_a = data_a;
            end
            en_prev_a = en_a;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            last_b = 8'h00;
            en_prev_b = 1'b0;
        end else begin
            if (en_b) begin
                int lat;
                check("b_en_double", {31'b0, en_prev_b}, 32'd0);
                check("b_en_expected", {31'b0, (exp_b.size() > 0)}, 32'd1);
                if (exp_b.size() > 0) begin
                    check("b_data", {24'b0, data_b}, {24'b0, exp_b.pop_front()});
                    lat = cyc - t0_b.pop_front();
                    check("b_latency", lat, (lat >= LAT_B - 1 && lat <= LAT_B + 1) ? lat : LAT_B);
                end
                last_b = data_b;
                en_cnt_b++;
            end else if (data_b !== last_b) begin
                check("b_data_stable", {24'b0, data_b}, {24'b0, last_b});
                last_b = data_b;
            end
            en_prev_b = en_b;
        end
    end

    function automatic void set_line(input bit sel_b, input logic v);
        if (sel_b) rxd_b = v;
        else       rxd_a = v;
    endfunction

    // Called at a falling clock edge; returns at a falling clock edge right
    // after the stop bit, so consecutive calls give back-to-back frames.
    // A bad stop bit is followed by hold_low extra low cycles, then idle high.
    task automatic send(input bit sel_b, input logic [7:0] b, input bit stop_ok, input int hold_low);
        int cpb;
        cpb = sel_b ? CPB_B : CPB_A;
        set_line(sel_b, 1'b0);
        if (stop_ok) begin
            if (sel_b) begin exp_b.push_back(b); t0_b.push_back(cyc); end
            else       begin exp_a.push_back(b); t0_a.push_back(cyc); end
        end
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel_b, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(sel_b, stop_ok);
        repeat (cpb) @(negedge clk);
        if (!stop_ok) begin
            repeat (hold_low) @(negedge clk);
            set_line(sel_b, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        rxd_a = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] prev;
        int base;

        // Reset with the line toggling: outputs must stay cleared.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rxd_a = ~rxd_a;
            rxd_b = ~rxd_b;
            @(negedge clk);
            check("rst_en", {31'b0, en_a}, 32'd0);
            check("rst_data", {24'b0, data_a}, 32'd0);
        end
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(20);
        check("post_rst_no_en", en_cnt_a, 32'd0);
        check("post_rst_data", {24'b0, data_a}, 32'd0);

        // Single byte.
        send(1'b0, 8'h41, 1'b1, 0);
        idle(10);
        check("single_count", en_cnt_a, 32'd1);
        check("single_data", {24'b0, data_a}, 32'h41);

        // Back-to-back with no idle gap.
        base = en_cnt_a;
        send(1'b0, 8'h55, 1'b1, 0);
        send(1'b0, 8'hAA, 1'b1, 0);
        send(1'b0, 8'h00, 1'b1, 0);
        send(1'b0, 8'hFF, 1'b1, 0);
        idle(10);
        check("b2b_count", en_cnt_a - base, 32'd4);
        check("b2b_last", {24'b0, data_a}, 32'hFF);

        // Short low glitch must be rejected, next frame still decoded.
        base = en_cnt_a;
        rxd_a = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check("glitch_no_en", en_cnt_a - base, 32'd0);
        send(1'b0, 8'h3C, 1'b1, 0);
        idle(10);
        check("glitch_next", {24'b0, data_a}, 32'h3C);

        // Framing error: stop bit low, line held low for a while.
        base = en_cnt_a;
        prev = data_a;
        send(1'b0, 8'h81, 1'b0, 30);
        idle(20);
        check("frame_err_no_en", en_cnt_a - base, 32'd0);
        check("frame_err_hold", {24'b0, data_a}, {24'b0, prev});
        send(1'b0, 8'h7E, 1'b1, 0);
        idle(10);
        check("frame_err_next", {24'b0, data_a}, 32'h7E);

        // Randomised mix of good and bad frames with random gaps.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            bit ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send(1'b0, b, ok, ok ? 0 : $urandom_range(0, 20));
            if (!ok) idle($urandom_range(4, 12));
            else if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 12));
        end
        idle(12);
        check("rand_drained", exp_a.size(), 32'd0);

        // Reset in the middle of bit 4 of 0x12: frame dropped, DATA cleared.
        base = en_cnt_a;
        rxd_a = 1'b0;
        repeat (CPB_A) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd_a = 1'(8'h12 >> i);
            repeat (CPB_A) @(negedge clk);
        end
        rxd_a = 1'b1;
        repeat (CPB_A / 2) @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'b0, data_a}, 32'd0);
        rst_a = 1'b0;
        idle(100);
        check("midrst_no_en", en_cnt_a - base, 32'd0);
        check("midrst_data_after", {24'b0, data_a}, 32'd0);

        // Default divider: "Hi\n".
        send(1'b1, 8'h48, 1'b1, 0);
        send(1'b1, 8'h69, 1'b1, 0);
        send(1'b1, 8'h0A, 1'b1, 0);
        rxd_b = 1'b1;
        repeat (20) @(negedge clk);
        check("hi_count", en_cnt_b, 32'd3);
        check("hi_last", {24'b0, data_b}, 32'h0A);
        check("hi_drained", exp_b.size(), 32'd0);
        check("a_drained", exp_a.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #(10 * 80000);
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serialc_rx.md
Name: serialc_rx

Overview:
- UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first.
- Deserialises the RXD line into bytes and emits a one-cycle EN strobe with DATA valid.
- Used in the simulation UART model on the DUT's transmit pin; the model prints each received byte as a character.
- Also synthesizable for on-chip debug consoles.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200 baud). Legal range 4..65535.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- RXD  input  1  serial line, asynchronous to CLK, idle high.
- DATA  output  8  last correctly received byte.
- EN  output  1  one-cycle strobe; DATA is valid in the same cycle.

Behaviour:
- Reset values (RST high, asynchronous): DATA=8'h00, EN=0, state IDLE, all counters 0, synchroniser flops 1.
- Input conditioning: RXD passes through a 2-flop synchroniser, initialised to 1. All decisions use the synchronised value rxs.
- Bit counter: cnt counts CLKS_PER_BIT-1 down to 0, then reloads. Width is $clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rxs==0 → load cnt=(CLKS_PER_BIT/2)-1 (integer division), go to START.
- START:
  - Count cnt to 0, then sample rxs (mid-start-bit).
  - rxs==1 → glitch; return to IDLE, no output.
  - rxs==0 → reload cnt=CLKS_PER_BIT-1, bit index=0, go to DATA.
- DATA:
  - Each time cnt reaches 0, sample rxs into shift register bit [index], LSB first, and reload cnt.
  - After index 7 is sampled, go to STOP.
- STOP:
  - When cnt reaches 0, sample rxs.
  - rxs==1 → on the next clock edge DATA<=shift register and EN<=1 for exactly one cycle; go to IDLE.
  - rxs==0 → framing error: DATA unchanged, EN stays 0; go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE. A break condition (line held low) therefore never yields bytes.
- EN is never high in two consecutive cycles.
- DATA holds its value between frames and changes only together with EN.
- Latency: EN asserts 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the RXD falling edge. This is about mid-stop-bit, so back-to-back frames with no idle gap are received without loss.
- Baud tolerance: sampling at bit centre tolerates about ±4% clock/baud mismatch.
- RST asserted mid-frame: frame aborted, no EN. After RST deasserts, the receiver restarts in IDLE and needs a falling edge. If it restarts while RXD is low mid-frame, that is treated as a start bit; misalignment is acceptable.

Decomposition:
- Shared package uart_pkg holds:
  - state enum type (IDLE, START, DATA, STOP, WAIT_IDLE);
  - constant DATA_BITS=8;
  - function computing the counter width.
- Optional single sub-module sync2 (2-flop synchroniser with reset value parameter) for reuse by other asynchronous inputs. Everything else stays in serialc_rx.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Reset: hold RST high 5 cycles with RXD toggling → DATA=0x00, EN=0 throughout; no EN for 20 cycles after release with RXD=1.
- Single byte: drive 0x41 ('A') frame at 8 clocks/bit → exactly one EN pulse, DATA=0x41, EN within 3+4+72±1 cycles of start edge.
- Back-to-back: send 0x55, 0xAA, 0x00, 0xFF with no idle gap → four EN pulses with DATA in that order; DATA stable between pulses.
- Glitch rejection: pull RXD low 2 cycles then high → no EN, state returns to IDLE. A following valid 0x3C frame is received correctly.
- Framing error: send 0x81 with stop bit 0, hold low 30 cycles, release → no EN, DATA keeps previous value. Next valid 0x7E frame is received.
- Mid-frame reset and default parameter: assert RST during bit 4 of 0x12 → no EN, DATA=0x00. Then with CLKS_PER_BIT=868, string "Hi\n" yields EN pulses with 0x48, 0x69, 0x0A.
